// File: rtl/booth_r16_mul_datapath.sv
// Iterative unsigned multiplier that retires one radix-16 Booth digit per clock.
// It produces the exact product and a round-to-nearest-even upper half, behind a start/done handshake.
module booth_r16_mul_datapath #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand_i,
    input  logic [WIDTH-1:0]     multiplier_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic [WIDTH-1:0]     product_rounded_o,
    output logic                 done
);

    localparam int unsigned NDIG = (WIDTH + 4) / 4;
    localparam int unsigned BW   = 4 * NDIG + 1;
    localparam int unsigned LW   = 4 * NDIG;
    localparam int unsigned AW   = WIDTH + 5;
    localparam int unsigned HW   = 2 * WIDTH - LW;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_ROUND,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [BW-1:0]        mplier_q, mplier_d;
    logic [AW-1:0]        m3_q, m3_d;
    logic [AW-1:0]        m5_q, m5_d;
    logic [AW-1:0]        m7_q, m7_d;
    logic [AW-1:0]        acc_hi_q, acc_hi_d;
    logic [LW-1:0]        acc_lo_q, acc_lo_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH-1:0]     rounded_q, rounded_d;
    logic                 done_q, done_d;

    logic [AW-1:0]        mc_ext;
    logic [4:0]           dig;
    logic                 dig_neg;
    logic [4:0]           dig_mag;
    logic [AW-1:0]        pp_mag;
    logic [AW-1:0]        pp;
    logic [AW-1:0]        sum;
    logic [AW-1:0]        shift_hi;
    logic [LW-1:0]        shift_lo;
    logic [2*WIDTH-1:0]   prod_c;
    logic                 rnd_up;

    // Booth digit from the low five multiplier bits: signed {b4..b1} plus b0.
    always_comb begin
        mc_ext  = AW'(mcand_q);
        dig     = {mplier_q[4], mplier_q[4:1]} + {4'b0000, mplier_q[0]};
        dig_neg = dig[4];
        dig_mag = dig_neg ? (5'd0 - dig) : dig;
        pp_mag  = '0;
        case (dig_mag)
            5'd1:    pp_mag = mc_ext;
            5'd2:    pp_mag = mc_ext << 1;
            5'd3:    pp_mag = m3_q;
            5'd4:    pp_mag = mc_ext << 2;
            5'd5:    pp_mag = m5_q;
            5'd6:    pp_mag = m3_q << 1;
            5'd7:    pp_mag = m7_q;
            5'd8:    pp_mag = mc_ext << 3;
            default: pp_mag = '0;
        endcase
        pp       = dig_neg ? (AW'(0) - pp_mag) : pp_mag;
        sum      = acc_hi_q + pp;
        shift_hi = {{4{sum[AW-1]}}, sum[AW-1:4]};
        shift_lo = {sum[3:0], acc_lo_q[LW-1:4]};
        prod_c   = {shift_hi[HW-1:0], shift_lo};
        rnd_up   = prod_c[WIDTH-1] & ((|prod_c[WIDTH-2:0]) | prod_c[WIDTH]);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        m3_d      = m3_q;
        m5_d      = m5_q;
        m7_d      = m7_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        product_d = product_q;
        rounded_d = rounded_q;
        done_d    = done_q;

        if (start) begin
            state_d  = S_LOAD;
            mcand_d  = multiplicand_i;
            mplier_d = {BW'(multiplier_i), 1'b0};
            done_d   = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    m3_d     = (mc_ext << 1) + mc_ext;
                    m5_d     = (mc_ext << 2) + mc_ext;
                    m7_d     = (mc_ext << 3) - mc_ext;
                    acc_hi_d = '0;
                    acc_lo_d = '0;
                    cnt_d    = '0;
                    state_d  = S_ITER;
                end
                S_ITER: begin
                    acc_hi_d = shift_hi;
                    acc_lo_d = shift_lo;
                    mplier_d = mplier_q >> 4;
                    cnt_d    = cnt_q + CW'(1);
                    // Last digit: publish the final product and its rounding together.
                    if (cnt_q == CW'(NDIG - 1)) begin
                        product_d = prod_c;
                        rounded_d = prod_c[2*WIDTH-1:WIDTH] + WIDTH'(rnd_up);
                        done_d    = 1'b1;
                        state_d   = S_ROUND;
                    end
                end
                S_ROUND: state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            m3_q      <= '0;
            m5_q      <= '0;
            m7_q      <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            product_q <= '0;
            rounded_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            m3_q      <= m3_d;
            m5_q      <= m5_d;
            m7_q      <= m7_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            product_q <= product_d;
            rounded_q <= rounded_d;
            done_q    <= done_d;
        end
    end

    assign product_o         = product_q;
    assign product_rounded_o = rounded_q;
    assign done              = done_q;

endmodule

// File: tb/tb_booth_r16_mul_datapath.sv
// Scoreboard bench for booth_r16_mul_datapath at WIDTH=16.
module tb_booth_r16_mul_datapath;

    localparam int W         = 16;
    localparam int MULCYCLES = 6;

    typedef struct {
        logic [2*W-1:0] p;
        logic [W-1:0]   r;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     mcand;
    logic [W-1:0]     mplier;
    logic [2*W-1:0]   product_o;
    logic [W-1:0]     product_rounded_o;
    logic             done;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    booth_r16_mul_datapath #(.WIDTH(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .multiplicand_i    (mcand),
        .multiplier_i      (mplier),
        .product_o         (product_o),
        .product_rounded_o (product_rounded_o),
        .done              (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model: exact product, RTNE by adding 0x7FFF plus the kept lsb.
    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [32:0] t;
        e.p = 32'(a) * 32'(b);
        t   = {1'b0, e.p} + 33'h0_0000_7FFF + 33'(e.p[16]);
        e.r = t[31:16];
        sb.push_back(e);
    endtask

    // Called #1 after a rising edge; the next edge samples start. Operands are scrambled afterwards.
    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(posedge clk); #1;
        start  = 1'b0;
        mcand  = W'($urandom);
        mplier = W'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; mcand = 16'h1234; mplier = 16'h5678;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; start = 1'b0;
        n_tests++;
        if (product_o !== '0 || product_rounded_o !== '0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: product=%h rounded=%h done=%b, required 0/0/0",
                     product_o, product_rounded_o, done);
        end
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_priority: done=%b after start under reset, required 0", done);
        end
    endtask

    task automatic test_table(input string name, input logic [W-1:0] as[], input logic [W-1:0] bs[]);
        int   lat;
        exp_t e;
        foreach (as[i]) begin
            push_exp(as[i], bs[i]);
            pulse_start(as[i], bs[i]);
            wait_done(lat);
            e = sb.pop_front();
            n_tests++;
            if (lat !== MULCYCLES) begin
                n_fail++;
                $display("FAIL %s_latency[%0d]: got %0d cycles, required %0d", name, i, lat, MULCYCLES);
            end
            n_tests++;
            if (product_o !== e.p) begin
                n_fail++;
                $display("FAIL %s_product[%0d] %h*%h: got %h, required %h", name, i, as[i], bs[i], product_o, e.p);
            end
            n_tests++;
            if (product_rounded_o !== e.r) begin
                n_fail++;
                $display("FAIL %s_rounded[%0d] %h*%h: got %h, required %h", name, i, as[i], bs[i], product_rounded_o, e.r);
            end
        end
    endtask

    task automatic test_corners;
        logic [W-1:0] a[] = '{16'h0000, 16'hFFFF, 16'h0001, 16'hFFFF};
        logic [W-1:0] b[] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000};
        test_table("corner", a, b);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL corner_scoreboard: %0d leftover entries, required 0", sb.size());
        end
    endtask

    task automatic test_rounding;
        logic [W-1:0] a[] = '{16'h0180, 16'h0080, 16'h00C1, 16'h00BF, 16'h0081};
        logic [W-1:0] b[] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
        test_table("round", a, b);
        n_tests++;
        if (product_rounded_o !== 16'h0001) begin
            n_fail++;
            $display("FAIL round_const: 0x81*0x100 rounded got %h, required 0001", product_rounded_o);
        end
    endtask

    task automatic test_booth;
        logic [W-1:0] a[] = '{16'h8888, 16'h1234, 16'h7777, 16'hABCD, 16'hFFFF};
        logic [W-1:0] b[] = '{16'h7777, 16'hF0F0, 16'h8888, 16'h9999, 16'h8000};
        test_table("booth", a, b);
    endtask

    task automatic test_back_to_back;
        int   lat;
        exp_t e;
        push_exp(16'h4321, 16'h1357);
        pulse_start(16'h4321, 16'h1357);
        wait_done(lat);
        e = sb.pop_front();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b1 || product_o !== e.p || product_rounded_o !== e.r) begin
            n_fail++;
            $display("FAIL hold: done=%b product=%h rounded=%h, required 1/%h/%h",
                     done, product_o, product_rounded_o, e.p, e.r);
        end
        push_exp(16'hBEEF, 16'hCAFE);
        pulse_start(16'hBEEF, 16'hCAFE);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_drop: done=%b after new start, required 0", done);
        end
        wait_done(lat);
        e = sb.pop_front();
        n_tests++;
        if (lat !== MULCYCLES || product_o !== e.p || product_rounded_o !== e.r) begin
            n_fail++;
            $display("FAIL b2b_result: lat=%0d product=%h rounded=%h, required %0d/%h/%h",
                     lat, product_o, product_rounded_o, MULCYCLES, e.p, e.r);
        end
    endtask

    task automatic test_restart;
        int   lat;
        exp_t e;
        pulse_start(16'hFFFF, 16'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        push_exp(16'h0123, 16'h4567);
        pulse_start(16'h0123, 16'h4567);
        wait_done(lat);
        e = sb.pop_front();
        n_tests++;
        if (lat !== MULCYCLES || product_o !== e.p || product_rounded_o !== e.r) begin
            n_fail++;
            $display("FAIL restart: lat=%0d product=%h rounded=%h, required %0d/%h/%h",
                     lat, product_o, product_rounded_o, MULCYCLES, e.p, e.r);
        end
        // start held high for three edges with changing operands: only the last counts.
        start = 1'b1; mcand = 16'h1111; mplier = 16'h2222;
        @(posedge clk); #1;
        mcand = 16'h3333; mplier = 16'h4444;
        @(posedge clk); #1;
        mcand = 16'h9ABC; mplier = 16'hDEF0;
        push_exp(16'h9ABC, 16'hDEF0);
        @(posedge clk); #1;
        start = 1'b0; mcand = '0; mplier = '0;
        wait_done(lat);
        e = sb.pop_front();
        n_tests++;
        if (lat !== MULCYCLES || product_o !== e.p || product_rounded_o !== e.r) begin
            n_fail++;
            $display("FAIL held_start: lat=%0d product=%h rounded=%h, required %0d/%h/%h",
                     lat, product_o, product_rounded_o, MULCYCLES, e.p, e.r);
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        pulse_start(16'hFEDC, 16'hBA98);
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if (product_o !== '0 || product_rounded_o !== '0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: product=%h rounded=%h done=%b, required 0/0/0",
                     product_o, product_rounded_o, done);
        end
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: done high in %0d cycles, required 0", seen);
        end
    endtask

    task automatic test_random;
        int           lat;
        exp_t         e;
        logic [W-1:0] a, b;
        for (int i = 0; i < 100; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            push_exp(a, b);
            pulse_start(a, b);
            wait_done(lat);
            e = sb.pop_front();
            n_tests++;
            if (lat !== MULCYCLES || product_o !== e.p || product_rounded_o !== e.r) begin
                n_fail++;
                $display("FAIL random[%0d] %h*%h: lat=%0d product=%h rounded=%h, required %0d/%h/%h",
                         i, a, b, lat, product_o, product_rounded_o, MULCYCLES, e.p, e.r);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
        @(posedge clk); #1;
        test_reset;
        test_corners;
        test_rounding;
        test_booth;
        test_back_to_back;
        test_restart;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
